// File: rtl/data_mem_unit.sv
// Word-addressed data memory with a fixed-latency wait-state controller for the multi-cycle core.
// Optional address/strobe fault checking is enabled by defining DMEM_FAULT_EN.
module data_mem_unit #(
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_load,
  input  logic        mem_store,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        mem_busy,
  output logic        mem_ready,
  output logic        addr_fault
);

  localparam int unsigned DEPTH = 32'(1) << DEPTH_LOG2;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic [31:0]           req_data;
  logic                  req_store;
  logic                  req_fault;

  logic [31:0]           mem [DEPTH];

  logic                  accept_c;
  logic                  fault_in_c;
  logic                  idle_c;
  logic                  enter_resp_c;
  logic [DEPTH_LOG2-1:0] idx_c;
  logic [31:0]           wdata_c;
  logic                  store_c;
  logic                  fault_c;

`ifdef DMEM_FAULT_EN
  // Both strobes are accepted so the core sees a faulted completion rather than a hang.
  assign accept_c   = mem_load | mem_store;
  assign fault_in_c = (addr[1:0] != 2'b00) || (addr[31:DEPTH_LOG2+2] != '0) ||
                      (mem_load & mem_store);
`else
  logic unused_addr_bits;
  assign accept_c         = mem_load ^ mem_store;
  assign fault_in_c       = 1'b0;
  assign unused_addr_bits = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};
`endif

  // With zero wait states RESP is entered on the accepting edge, so use live inputs there.
  assign idle_c       = (state == S_IDLE);
  assign idx_c        = idle_c ? addr[DEPTH_LOG2+1:2] : req_idx;
  assign wdata_c      = idle_c ? write_data : req_data;
  assign store_c      = idle_c ? mem_store : req_store;
  assign fault_c      = idle_c ? fault_in_c : req_fault;
  assign enter_resp_c = (idle_c && accept_c && (WAIT_STATES == 0)) ||
                        ((state == S_WAIT) && (cnt == '0));

  // Storage array: never reset; write is suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (reset && enter_resp_c && store_c && !fault_c) begin
      mem[idx_c] <= wdata_c;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      req_idx    <= '0;
      req_data   <= '0;
      req_store  <= 1'b0;
      req_fault  <= 1'b0;
      read_data  <= '0;
      mem_busy   <= 1'b0;
      mem_ready  <= 1'b0;
      addr_fault <= 1'b0;
    end else begin
      mem_ready  <= 1'b0;
      addr_fault <= 1'b0;

      if (enter_resp_c) begin
        mem_ready  <= 1'b1;
        addr_fault <= fault_c;
        if (!store_c && !fault_c) begin
          read_data <= mem[idx_c];
        end
      end

      case (state)
        S_IDLE: begin
          if (accept_c) begin
            req_idx   <= addr[DEPTH_LOG2+1:2];
            req_data  <= write_data;
            req_store <= mem_store;
            req_fault <= fault_in_c;
            mem_busy  <= 1'b1;
            cnt       <= CNT_LOAD;
            state     <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state <= S_RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          mem_busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed self-checking bench for data_mem_unit at 0, 1 and 3 wait states.
// Misaligned/both-strobe/wrap expectations follow whether DMEM_FAULT_EN is defined.
module tb_data_mem_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ld   [3];
  logic        st   [3];
  logic [31:0] rd   [3];
  logic        busy [3];
  logic        rdy  [3];
  logic        flt  [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_unit #(.DEPTH_LOG2(8), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .mem_load(ld[0]), .mem_store(st[0]), .addr(addr),
    .write_data(wdata), .read_data(rd[0]), .mem_busy(busy[0]), .mem_ready(rdy[0]),
    .addr_fault(flt[0]));

  data_mem_unit #(.DEPTH_LOG2(8), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .reset(reset), .mem_load(ld[1]), .mem_store(st[1]), .addr(addr),
    .write_data(wdata), .read_data(rd[1]), .mem_busy(busy[1]), .mem_ready(rdy[1]),
    .addr_fault(flt[1]));

  data_mem_unit #(.DEPTH_LOG2(8), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(reset), .mem_load(ld[2]), .mem_store(st[2]), .addr(addr),
    .write_data(wdata), .read_data(rd[2]), .mem_busy(busy[2]), .mem_ready(rdy[2]),
    .addr_fault(flt[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // kind: 0 = load, 1 = store, 2 = both strobes. lat = cycles from accepting edge to ready (0 = none).
  task automatic access(input int i, input int kind, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] data, output logic fault,
                        output logic busy_seen, output logic rdy_after, output logic busy_after);
    addr       = a;
    wdata      = d;
    ld[i]      = (kind != 1);
    st[i]      = (kind != 0);
    lat        = 0;
    data       = '0;
    fault      = 1'b0;
    busy_seen  = 1'b0;
    rdy_after  = 1'b0;
    busy_after = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) begin
        ld[i] = 1'b0;
        st[i] = 1'b0;
        addr  = 32'hFFFF_FFFC;
        wdata = 32'h0BAD_0BAD;
      end
      if (rdy[i]) begin
        lat       = k;
        data      = rd[i];
        fault     = flt[i];
        busy_seen = busy[i];
        break;
      end
    end
    if (lat != 0) begin
      tick();
      rdy_after  = rdy[i];
      busy_after = busy[i];
    end
  endtask

  int          lat;
  logic [31:0] dat;
  logic        f, b, ra, ba, seen;

  initial begin
    reset = 1'b1;
    addr  = '0;
    wdata = '0;
    for (int i = 0; i < 3; i++) begin
      ld[i] = 1'b0;
      st[i] = 1'b0;
    end

    #2 reset = 1'b0;
    #1;
    check("reset_read_data", rd[1], 32'h0);
    check("reset_busy", 32'(busy[1]), 32'h0);
    check("reset_ready", 32'(rdy[1]), 32'h0);
    check("reset_fault", 32'(flt[1]), 32'h0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    tick();

    // One wait state: store then load back.
    access(1, 1, 32'h10, 32'hDEAD_BEEF, lat, dat, f, b, ra, ba);
    check("ws1_store_latency", 32'(lat), 32'd2);
    check("ws1_store_busy_in_ready", 32'(b), 32'h1);
    check("ws1_store_no_fault", 32'(f), 32'h0);
    check("ws1_store_keeps_read_data", dat, 32'h0);
    check("ws1_ready_one_cycle", 32'(ra), 32'h0);
    check("ws1_busy_drops", 32'(ba), 32'h0);
    access(1, 0, 32'h10, 32'h0, lat, dat, f, b, ra, ba);
    check("ws1_load_latency", 32'(lat), 32'd2);
    check("ws1_load_data", dat, 32'hDEAD_BEEF);

    // Zero wait states, strobe pulsed during RESP must be ignored.
    access(0, 1, 32'h0, 32'h1234_5678, lat, dat, f, b, ra, ba);
    check("ws0_store_latency", 32'(lat), 32'd1);
    addr  = 32'h0;
    ld[0] = 1'b1;
    tick();
    ld[0] = 1'b0;
    check("ws0_load_ready_next_cycle", 32'(rdy[0]), 32'h1);
    check("ws0_load_data", rd[0], 32'h1234_5678);
    ld[0] = 1'b1;
    tick();
    ld[0] = 1'b0;
    seen  = rdy[0];
    repeat (3) begin
      tick();
      seen = seen | rdy[0];
    end
    check("ws0_resp_strobe_ignored", 32'(seen), 32'h0);
    check("ws0_idle_after", 32'(busy[0]), 32'h0);

    // Three wait states, reset asserted during WAIT discards the store.
    access(2, 1, 32'h20, 32'hA5A5_A5A5, lat, dat, f, b, ra, ba);
    check("ws3_store_latency", 32'(lat), 32'd4);
    addr  = 32'h20;
    wdata = 32'h55;
    st[2] = 1'b1;
    tick();
    st[2] = 1'b0;
    tick();
    check("ws3_busy_in_wait", 32'(busy[2]), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_busy", 32'(busy[2]), 32'h0);
    check("async_reset_ready", 32'(rdy[2]), 32'h0);
    check("async_reset_read_data", rd[1], 32'h0);
    @(posedge clk);
    #2 reset = 1'b1;
    tick();
    access(2, 0, 32'h20, 32'h0, lat, dat, f, b, ra, ba);
    check("ws3_load_latency", 32'(lat), 32'd4);
    check("ws3_reset_discarded_store", dat, 32'hA5A5_A5A5);

    // Misaligned, both-strobe and out-of-range accesses.
    access(1, 1, 32'h10, 32'h1111_1111, lat, dat, f, b, ra, ba);
    check("pre_store_latency", 32'(lat), 32'd2);
    access(1, 1, 32'h13, 32'h2222_2222, lat, dat, f, b, ra, ba);
    check("misaligned_latency", 32'(lat), 32'd2);
`ifdef DMEM_FAULT_EN
    check("misaligned_fault", 32'(f), 32'h1);
    access(1, 0, 32'h10, 32'h0, lat, dat, f, b, ra, ba);
    check("misaligned_word_unchanged", dat, 32'h1111_1111);
    access(1, 0, 32'h13, 32'h0, lat, dat, f, b, ra, ba);
    check("faulted_load_fault", 32'(f), 32'h1);
    check("faulted_load_keeps_data", dat, 32'h1111_1111);
    access(1, 2, 32'h10, 32'h3333_3333, lat, dat, f, b, ra, ba);
    check("both_strobes_latency", 32'(lat), 32'd2);
    check("both_strobes_fault", 32'(f), 32'h1);
    access(1, 1, 32'h410, 32'h4444_4444, lat, dat, f, b, ra, ba);
    check("out_of_range_fault", 32'(f), 32'h1);
    access(1, 0, 32'h10, 32'h0, lat, dat, f, b, ra, ba);
    check("faulted_writes_suppressed", dat, 32'h1111_1111);
`else
    check("misaligned_no_fault", 32'(f), 32'h0);
    access(1, 0, 32'h10, 32'h0, lat, dat, f, b, ra, ba);
    check("misaligned_word_written", dat, 32'h2222_2222);
    access(1, 2, 32'h10, 32'h3333_3333, lat, dat, f, b, ra, ba);
    check("both_strobes_dropped", 32'(lat), 32'd0);
    access(1, 1, 32'h410, 32'h4444_4444, lat, dat, f, b, ra, ba);
    check("wrap_store_no_fault", 32'(f), 32'h0);
    access(1, 0, 32'h10, 32'h0, lat, dat, f, b, ra, ba);
    check("wrap_store_aliases_word", dat, 32'h4444_4444);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Word-addressed data memory with a wait-state controller, sitting directly downstream of the multi-cycle CPU core. It consumes the core's `mem_load`/`mem_store` strobes, the ALU-computed byte address and `read_value2` as store data, and returns `read_data` plus a completion handshake. Access latency is set by a parameter so the core's execute/write-back sequencing can be exercised against a slow memory.

## Interface
- `DEPTH_LOG2`, default 8: memory holds 2^DEPTH_LOG2 32-bit words.
- `WAIT_STATES`, default 1: extra cycles inserted before completion; legal range 0–15.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_load`  in  1  load request strobe from the core.
- `mem_store`  in  1  store request strobe from the core.
- `addr`  in  32  byte address; the word index is `addr[DEPTH_LOG2+1:2]`.
- `write_data`  in  32  store data, driven from the core's `read_value2`.
- `read_data`  out  32  load result; holds the last completed load's value.
- `mem_busy`  out  1  high while a request is in flight.
- `mem_ready`  out  1  one-cycle completion pulse.
- `addr_fault`  out  1  one-cycle fault pulse. Present only with `DMEM_FAULT_EN`; otherwise tied 0.

## Operation
- The controller has three states: IDLE, WAIT and RESP.
- **IDLE:**
  - A request is accepted when exactly one of `mem_load`/`mem_store` is high.
  - On acceptance, `addr`, `write_data` and the request type are latched, and `mem_busy` goes high.
  - The next state is WAIT if `WAIT_STATES > 0`, otherwise RESP.
  - A wait counter loads `WAIT_STATES - 1`.
- **WAIT:**
  - The counter decrements each cycle.
  - When the counter is 0, the next state is RESP.
- **RESP transition:**
  - On the edge entering RESP, a store writes its latched data to the latched word.
  - On the same edge, a load updates `read_data`.
- **RESP:**
  - `mem_ready` is 1 for exactly this cycle.
  - `mem_busy` drops with the same edge that leaves RESP.
  - The next state is always IDLE.
- Strobes that arrive while not in IDLE are ignored. There is no queueing.
- If both strobes are high in IDLE, the request is not accepted and memory is not modified.
- Latched inputs are used for the whole access; input changes after acceptance have no effect.
- Memory contents are not cleared by reset. The bench initialises them via hierarchical access or `$readmemh`.

## Timing
- **Reset values:** `read_data` = 0, `mem_busy` = 0, `mem_ready` = 0, `addr_fault` = 0, state = IDLE, wait counter = 0.
- **Latency:** request sampled at edge N → `mem_ready` high during cycle N+1+`WAIT_STATES`.
  - With `WAIT_STATES` = 0: ready in cycle N+1.
  - With default `WAIT_STATES` = 1: ready in cycle N+2.
- `read_data` is valid from the `mem_ready` cycle onward and is stable until the next load completes. A store never changes it.
- The earliest next acceptance is the cycle after `mem_ready`, so back-to-back throughput is one access per `WAIT_STATES`+2 cycles.
- **Reset asserted mid-access:**
  - An access that has not yet reached RESP is discarded: no memory write, no `read_data` update.
  - Outputs return to their reset values immediately (asynchronously).
- **Address wrap without fault checking:** upper address bits are ignored, so addresses wrap modulo 4·2^DEPTH_LOG2 bytes.

## Configuration
- Macro: `DMEM_FAULT_EN`.
- **Defined:**
  - A request is faulted if `addr[1:0]` ≠ 0, if any address bit above `DEPTH_LOG2+1` is set, or if both strobes are high in IDLE.
  - A faulted request still runs the full IDLE→WAIT→RESP sequence with the same latency.
  - In RESP, `addr_fault` = 1 together with `mem_ready` = 1.
  - A faulted access performs no memory write and leaves `read_data` unchanged.
  - A both-strobes request is accepted as a faulted access.
- **Not defined:**
  - `addr_fault` is constant 0.
  - Low address bits and out-of-range bits are ignored (wrap as above).
  - A both-strobes request is silently dropped.

## Test plan
- **Reset:** assert `reset`=0 mid-cycle → all outputs read 0 asynchronously, before the next clock edge.
- **Store then load:** `WAIT_STATES`=1; store `32'hDEADBEEF` to `addr` 0x10, then load 0x10 → `mem_ready` two cycles after each request, and `read_data` = `32'hDEADBEEF` in the load's ready cycle.
- **Zero wait states with overlapping strobe:** `WAIT_STATES`=0; load `addr` 0x0 holding 0x12345678 → ready the next cycle with data 0x12345678. A strobe pulsed during RESP is ignored (no second ready).
- **Reset during WAIT:** store 0x55 to 0x20 with `WAIT_STATES`=3, then `reset`=0 during WAIT → a later load from 0x20 returns the old contents, not 0x55.
- **Misaligned access, fault checking on:** `DMEM_FAULT_EN` defined; store to 0x13 → `addr_fault`=1 and `mem_ready`=1 together, with word 0x10 unchanged.
- **Misaligned access, fault checking off:** `DMEM_FAULT_EN` not defined; store to 0x13 → word 0x10 is written and `addr_fault` stays 0.
